// File: rtl/cmp_stream_minmax_pkg.sv
// Shared types and helpers for the streaming min/max tracker.
// Holds the FSM state encoding, default widths and the signed less-than decode.
package cmp_pkg;

    localparam int N_DEF     = 32;
    localparam int IDX_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // a < b after a - b: the sign bit corrected by overflow.
    function automatic logic signed_lt(input logic v, input logic n);
        return n ^ v;
    endfunction

endpackage

// File: rtl/cmp_stream_minmax_cmp.sv
// Subtract-based comparator: flags of a_i - b_i (negative, zero, signed overflow).
// Purely combinational; no handshake.
module cmp_stream_minmax_cmp #(
    parameter int n = 32
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic         n_o,
    output logic         z_o,
    output logic         v_o
);

    logic [n-1:0] diff;

    assign diff = a_i - b_i;
    assign n_o  = diff[n-1];
    assign z_o  = (diff == '0);
    // Overflow only when operand signs differ and the result sign disagrees with a.
    assign v_o  = (a_i[n-1] ^ b_i[n-1]) & (diff[n-1] ^ a_i[n-1]);

endmodule

// File: rtl/cmp_stream_minmax.sv
// Frame-wise running min/max with first-occurrence indices and saturating count.
// Result registered one cycle after the in_last transfer; input stalls while the result waits.
module cmp_stream_minmax
    import cmp_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_min,
    output logic [N-1:0]     out_max,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_count
);

    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [N-1:0]     min_q, min_d, max_q, max_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d, cnt_q, cnt_d;
    logic [N-1:0]     out_min_q, out_max_q;
    logic [IDX_W-1:0] out_min_idx_q, out_max_idx_q, out_count_q;

    logic in_fire, out_fire;
    logic n_min, z_min, v_min, n_max, z_max, v_max;
    logic less, greater;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    cmp_stream_minmax_cmp #(.n(N)) u_cmp_min (
        .a_i (in_data),
        .b_i (min_q),
        .n_o (n_min),
        .z_o (z_min),
        .v_o (v_min)
    );

    cmp_stream_minmax_cmp #(.n(N)) u_cmp_max (
        .a_i (in_data),
        .b_i (max_q),
        .n_o (n_max),
        .z_o (z_max),
        .v_o (v_max)
    );

    // Strict in both directions so ties keep the earlier index.
    assign less    = signed_lt(v_min, n_min) & ~z_min;
    assign greater = ~signed_lt(v_max, n_max) & ~z_max;

    always_comb begin
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE) begin
            min_d     = in_data;
            max_d     = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            cnt_d     = IDX_W'(1);
        end else begin
            if (less) begin
                min_d     = in_data;
                min_idx_d = cnt_q;
            end
            if (greater) begin
                max_d     = in_data;
                max_idx_d = cnt_q;
            end
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = in_last ? HOLD : ACCUM;
            ACCUM:   if (in_fire && in_last) state_d = HOLD;
            HOLD:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            cnt_q     <= '0;
        end else if (in_fire) begin
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Result captured on the same edge that enters HOLD, then held until the next frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_min_q     <= '0;
            out_max_q     <= '0;
            out_min_idx_q <= '0;
            out_max_idx_q <= '0;
            out_count_q   <= '0;
        end else if (in_fire && in_last) begin
            out_min_q     <= min_d;
            out_max_q     <= max_d;
            out_min_idx_q <= min_idx_d;
            out_max_idx_q <= max_idx_d;
            out_count_q   <= cnt_d;
        end
    end

    assign out_min     = out_min_q;
    assign out_max     = out_max_q;
    assign out_min_idx = out_min_idx_q;
    assign out_max_idx = out_max_idx_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_cmp_stream_minmax.sv
// Self-checking bench for cmp_stream_minmax: directed scenarios plus random frames vs a queue model.
module tb_cmp_stream_minmax;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_min, out_max;
    logic [15:0] out_min_idx, out_max_idx, out_count;

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_min, s_out_max;
    logic [3:0]  s_out_min_idx, s_out_max_idx, s_out_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [15:0] mn_i;
        logic [15:0] mx_i;
        logic [15:0] cnt;
    } res_t;

    cmp_stream_minmax #(.N(32), .IDX_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max),
        .out_min_idx(out_min_idx), .out_max_idx(out_max_idx), .out_count(out_count)
    );

    cmp_stream_minmax #(.N(32), .IDX_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_min(s_out_min), .out_max(s_out_max),
        .out_min_idx(s_out_min_idx), .out_max_idx(s_out_max_idx), .out_count(s_out_count)
    );

    // Reference: scan the whole frame with signed arithmetic, strict compares, saturated indices.
    function automatic res_t model(input logic [31:0] f[$], input int iw);
        res_t r;
        int   sat = (1 << iw) - 1;
        int   mi = 0, xi = 0;
        r.mn = f[0];
        r.mx = f[0];
        for (int i = 1; i < f.size(); i++) begin
            if ($signed(f[i]) < $signed(r.mn)) begin r.mn = f[i]; mi = i; end
            if ($signed(f[i]) > $signed(r.mx)) begin r.mx = f[i]; xi = i; end
        end
        r.mn_i = 16'((mi > sat) ? sat : mi);
        r.mx_i = 16'((xi > sat) ? sat : xi);
        r.cnt  = 16'((f.size() > sat) ? sat : f.size());
        return r;
    endfunction

    function automatic res_t observed();
        return {out_min, out_max, out_min_idx, out_max_idx, out_count};
    endfunction

    function automatic res_t mk(input logic [31:0] mn, input logic [31:0] mx,
                                input int mi, input int xi, input int c);
        return {mn, mx, 16'(mi), 16'(xi), 16'(c)};
    endfunction

    task automatic push(input logic [31:0] d, input logic last, input int gap);
        int g = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (in_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] f[$], input int max_gap);
        for (int i = 0; i < f.size(); i++)
            push(f[i], i == f.size() - 1, $urandom_range(0, max_gap));
    endtask

    task automatic wait_out(output res_t r);
        int g = 0;
        while (out_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
        end
        r = observed();
    endtask

    task automatic release_out(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #22;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        n_tests++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required 0", observed());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_ties();
        logic [31:0] f[$] = '{32'd5, -32'sd3, 32'd7, -32'sd3, 32'd2};
        res_t got;
        push_frame(f, 0);
        wait_out(got);
        n_tests++;
        if (got !== mk(-32'sd3, 32'd7, 1, 2, 5)) begin
            n_fail++;
            $display("FAIL ties: got %h required %h", got, mk(-32'sd3, 32'd7, 1, 2, 5));
        end
        release_out(0);
    endtask

    task automatic test_single();
        push(32'h2A, 1'b1, 0);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
        n_tests++;
        if (observed() !== mk(32'h2A, 32'h2A, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL single: got %h required %h", observed(), mk(32'h2A, 32'h2A, 0, 0, 1));
        end
        release_out(1);
    endtask

    task automatic test_overflow();
        logic [31:0] f[$] = '{32'h7FFF_FFFF, 32'h8000_0000};
        res_t got;
        push_frame(f, 0);
        wait_out(got);
        n_tests++;
        if (got !== mk(32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 2)) begin
            n_fail++;
            $display("FAIL overflow: got %h required %h", got, mk(32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 2));
        end
        release_out(0);
    endtask

    task automatic test_backpressure();
        logic [31:0] f[$] = '{32'd10, -32'sd20, 32'd30};
        res_t snap, got;
        push_frame(f, 0);
        snap = observed();
        n_tests++;
        if (snap !== mk(-32'sd20, 32'd30, 1, 2, 3)) begin
            n_fail++;
            $display("FAIL bp_result: got %h required %h", snap, mk(-32'sd20, 32'd30, 1, 2, 3));
        end
        in_valid = 1'b1; in_data = 32'd4; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== snap) begin
                n_fail++;
                $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b outs=%h required 0 1 %h",
                         i, in_ready, out_valid, observed(), snap);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || observed() !== snap) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b outs=%h required 1 0 %h",
                     in_ready, out_valid, observed(), snap);
        end
        f = '{32'd4, 32'd4};
        push_frame(f, 0);
        wait_out(got);
        n_tests++;
        if (got !== mk(32'd4, 32'd4, 0, 0, 2)) begin
            n_fail++;
            $display("FAIL bp_next: got %h required %h", got, mk(32'd4, 32'd4, 0, 0, 2));
        end
        release_out(0);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] f[$] = '{32'd9, 32'd1};
        res_t got;
        push(32'd100, 1'b0, 0);
        push(-32'sd5, 1'b0, 0);
        push(32'd6, 1'b0, 0);
        @(negedge clk); rst_n = 1'b0; #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b outs=%h required 0 1 0",
                     out_valid, in_ready, observed());
        end
        @(negedge clk); rst_n = 1'b1;
        push_frame(f, 0);
        wait_out(got);
        n_tests++;
        if (got !== mk(32'd1, 32'd9, 1, 0, 2)) begin
            n_fail++;
            $display("FAIL after_reset: got %h required %h", got, mk(32'd1, 32'd9, 1, 0, 2));
        end
        release_out(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1; s_in_data = 32'(i); s_in_last = (i == 19);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        n_tests++;
        if (s_out_valid !== 1'b1 ||
            {s_out_min, s_out_max, s_out_min_idx, s_out_max_idx, s_out_count} !==
            {32'd0, 32'd19, 4'd0, 4'd15, 4'd15}) begin
            n_fail++;
            $display("FAIL saturation: vld=%b min=%0d max=%0d mi=%0d xi=%0d cnt=%0d required 1 0 19 0 15 15",
                     s_out_valid, s_out_min, s_out_max, s_out_min_idx, s_out_max_idx, s_out_count);
        end
        @(negedge clk); s_out_ready = 1'b1;
        @(posedge clk); #1; s_out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] f[$];
        logic [31:0] v;
        res_t got, exp;
        for (int k = 0; k < 30; k++) begin
            f.delete();
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                case ($urandom_range(0, 3))
                    0: v = 32'($signed($urandom_range(0, 4)) - 2);
                    1: v = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
                    default: v = $urandom;
                endcase
                f.push_back(v);
            end
            exp = model(f, 16);
            push_frame(f, 2);
            wait_out(got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random%0d: got %h required %h", k, got, exp);
            end
            release_out($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_ties();
        test_single();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_stream_minmax.md
Name: cmp_stream_minmax

Overview:
- Streaming consumer of the V/N/Z comparator flags.
- Accepts a frame of signed N-bit samples over a valid/ready handshake and tracks the running minimum and maximum together with their sample indices.
- Emits one result beat per frame.
- Sits directly downstream of the subtract-based comparator, which it instantiates twice per cycle: once against the current min and once against the current max.

Parameters:
- N, 32, sample width (two's complement).
- IDX_W, 16, width of the index and count fields.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_data  input  N  signed sample
- in_last  input  1  marks the final sample of a frame
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_min  output  N  smallest sample in the frame
- out_max  output  N  largest sample in the frame
- out_min_idx  output  IDX_W  index of the first occurrence of the min
- out_max_idx  output  IDX_W  index of the first occurrence of the max
- out_count  output  IDX_W  number of samples in the frame (saturating)

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
  - Reset forces state IDLE and in_ready=1.
  - out_valid, out_min, out_max, out_min_idx, out_max_idx and out_count all reset to 0.
  - Internal accumulators reset to 0.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1. On transfer:
    - cur_min=cur_max=in_data, min_idx=max_idx=0, count=1.
    - If in_last, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready=1. On transfer:
    - less = N^V from compare(in_data, cur_min).
    - greater = ~(N^V) & ~Z from compare(in_data, cur_max).
    - If less: cur_min<=in_data, min_idx<=count.
    - If greater: cur_max<=in_data, max_idx<=count.
    - count<=count+1, saturating at 2^IDX_W-1.
    - If in_last, go to HOLD.
  - HOLD: in_ready=0, out_valid=1.
    - Output registers are loaded on the same edge that enters HOLD.
    - Outputs are stable until out_ready; on out_ready go to IDLE.
- Latency and throughput:
  - out_valid rises the cycle after the in_last transfer.
  - Exactly one bubble cycle between frames: no input is accepted while in HOLD.
- Comparisons:
  - Signed comparison uses N^V so that overflowing subtractions are ordered correctly.
  - Comparisons are strict, so ties keep the earlier index.
- Saturation: once count saturates, later samples are still compared; a winning later sample records index 2^IDX_W-1.
- in_valid=0 in ACCUM: state and accumulators hold.
- Reset mid-frame: partial frame is discarded and out_valid drops immediately.
- Outputs are registered and hold their last values after the output transfer until the next frame completes.

Decomposition:
- Package cmp_pkg holds:
  - state enum typedef (IDLE, ACCUM, HOLD).
  - default N and IDX_W constants.
  - a function signed_lt(V,N) returning N^V.
- Sub-module: the existing comparator (parameter n=N), instantiated twice (u_cmp_min, u_cmp_max).
- No other hierarchy.

Test Plan:
- Frame 5, -3, 7, -3, 2 with in_last on 2 -> out_min=-3, out_min_idx=1 (tie keeps first), out_max=7, out_max_idx=2, out_count=5.
- Single-sample frame 0x0000002A with in_last -> min=max=0x2A, both idx=0, count=1, out_valid the next cycle.
- Overflow ordering: frame 0x7FFFFFFF, 0x80000000 -> out_max=0x7FFFFFFF idx 0, out_min=0x80000000 idx 1.
- Backpressure: out_ready=0 for 4 cycles after a frame:
  - in_ready=0 and outputs stable throughout.
  - On out_ready=1, in_ready=1 the next cycle.
  - The next frame's first sample is accepted in IDLE.
- rst_n pulsed low after 3 samples of a frame:
  - out_valid=0 and all outputs 0 immediately.
  - A following frame of 9, 1 yields min=1 idx 1, max=9 idx 0, count=2.
- IDX_W=4, 20-sample ascending frame 0..19 -> out_count=15, out_max=19, out_max_idx=15, out_min=0 idx 0.
